cart_ctrl: RTL and testbench

Cartridge memory controller between the download path, the CPU bus and the external cart ROM/RAM arrays.
- During download it sequences ROMINIT cart bytes into cart ROM and measures image size.
- After download it resolves the effective mapper (automatic or forced).
- At run time it arbitrates the shared memory port, translates CPU window addresses plus bank bits into ROM/RAM addresses, and returns read data with fixed latency.

---
 rtl/scv_pkg.sv | 73 +++++++
 rtl/cart_ctrl.sv | 135 +++++++++++++
 tb/tb_cart_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scv_pkg.sv
// Shared system types plus the cartridge state encoding and address decode.
package scv_pkg;

  localparam int unsigned ROM_AW = 17;
  localparam int unsigned RAM_AW = 13;
  localparam int unsigned CPU_AW = 15;

  typedef enum logic [2:0] {
    MAP_AUTO        = 3'd0,
    MAP_ROM8K       = 3'd1,
    MAP_ROM16K      = 3'd2,
    MAP_ROM32K      = 3'd3,
    MAP_ROM32K_RAM  = 3'd4,
    MAP_ROM64K      = 3'd5,
    MAP_ROM128K     = 3'd6,
    MAP_ROM128K_RAM = 3'd7
  } mapper_t;

  typedef enum logic [1:0] {
    CART_IDLE    = 2'd0,
    CART_LOAD    = 2'd1,
    CART_RESOLVE = 2'd2,
    CART_RUN     = 2'd3
  } cart_state_t;

  // Exclusive bounds on the highest downloaded address for each image size
  localparam logic [ROM_AW-1:0] SIZE_LIM_8K  = 17'h02000;
  localparam logic [ROM_AW-1:0] SIZE_LIM_16K = 17'h04000;
  localparam logic [ROM_AW-1:0] SIZE_LIM_32K = 17'h08000;
  localparam logic [ROM_AW-1:0] SIZE_LIM_64K = 17'h10000;

  // Bus 0xE000-0xFFFF, i.e. window offset 0x6000 and up
  localparam logic [CPU_AW-1:0] RAM_WIN_BASE = 15'h6000;

  typedef struct packed {
    logic [ROM_AW-1:0] rom_a;
    logic [RAM_AW-1:0] ram_a;
    logic              is_ram;
  } cart_map_t;

  // Pick the smallest plain ROM mapper that covers the downloaded image
  function automatic mapper_t size_to_mapper(input logic [ROM_AW-1:0] size_max);
    mapper_t m;
    if (size_max < SIZE_LIM_8K)       m = MAP_ROM8K;
    else if (size_max < SIZE_LIM_16K) m = MAP_ROM16K;
    else if (size_max < SIZE_LIM_32K) m = MAP_ROM32K;
    else if (size_max < SIZE_LIM_64K) m = MAP_ROM64K;
    else                              m = MAP_ROM128K;
    return m;
  endfunction

  // Translate a CPU window address plus bank bits into ROM/RAM targets
  function automatic cart_map_t cart_map(input mapper_t mapper,
                                         input logic [1:0] bank,
                                         input logic [CPU_AW-1:0] addr);
    cart_map_t m;
    logic      in_win;
    in_win   = (addr >= RAM_WIN_BASE);
    m.ram_a  = addr[RAM_AW-1:0];
    m.is_ram = 1'b0;
    case (mapper)
      MAP_ROM16K:                   m.rom_a = ROM_AW'(addr[13:0]);
      MAP_ROM32K, MAP_ROM32K_RAM:   m.rom_a = ROM_AW'(addr);
      MAP_ROM64K:                   m.rom_a = ROM_AW'({bank[0], addr});
      MAP_ROM128K, MAP_ROM128K_RAM: m.rom_a = {bank, addr};
      default:                      m.rom_a = ROM_AW'(addr[12:0]);
    endcase
    if (mapper == MAP_ROM32K_RAM)       m.is_ram = in_win && bank[0];
    else if (mapper == MAP_ROM128K_RAM) m.is_ram = in_win;
    return m;
  endfunction

endpackage

// File: rtl/cart_ctrl.sv
// Cartridge memory controller: download sequencing, mapper resolution and
// run-time CPU access to the shared cart ROM/RAM ports.
module cart_ctrl
  import scv_pkg::*;
(
  input  logic              CLK,
  input  logic              RESB,
  input  logic              ROMINIT_SEL_CART,
  input  logic [ROM_AW-1:0] ROMINIT_ADDR,
  input  logic [7:0]        ROMINIT_DATA,
  input  logic              ROMINIT_VALID,
  input  logic              ROMINIT_ACTIVE,
  input  mapper_t           MAPPER,
  input  logic              CPU_CE,
  input  logic [CPU_AW-1:0] CPU_A,
  input  logic              CPU_RE,
  input  logic              CPU_WE,
  input  logic [7:0]        CPU_D,
  input  logic [1:0]        CPU_BANK,
  output logic [7:0]        CPU_Q,
  output logic              CPU_DV,
  output logic              CPU_WAIT,
  output logic [ROM_AW-1:0] ROM_A,
  output logic [7:0]        ROM_D,
  output logic              ROM_WE,
  input  logic [7:0]        ROM_Q,
  output logic [RAM_AW-1:0] RAM_A,
  output logic [7:0]        RAM_D,
  output logic              RAM_WE,
  input  logic [7:0]        RAM_Q,
  output mapper_t           MAPPER_EFF
);

  cart_state_t       state_q, state_d;
  logic [ROM_AW-1:0] size_max_q, size_max_d;
  mapper_t           mapper_eff_q, mapper_eff_d;
  logic              dv_q, dv_d;
  logic              tgt_ram_q, tgt_ram_d;

  cart_map_t cmap;
  logic      dl_start;
  logic      cart_byte;
  logic      cpu_rd;
  logic      cpu_wr;

  // A write in the same cycle as a read takes priority and suppresses the read
  assign dl_start  = ROMINIT_ACTIVE && ROMINIT_SEL_CART;
  assign cart_byte = ROMINIT_VALID && ROMINIT_SEL_CART;
  assign cpu_wr    = CPU_CE && CPU_WE;
  assign cpu_rd    = CPU_CE && CPU_RE && !CPU_WE;
  assign cmap      = cart_map(mapper_eff_q, CPU_BANK, CPU_A);

  // State and tracking registers
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q      <= CART_IDLE;
      size_max_q   <= '0;
      mapper_eff_q <= MAP_ROM8K;
      dv_q         <= 1'b0;
      tgt_ram_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_max_q   <= size_max_d;
      mapper_eff_q <= mapper_eff_d;
      dv_q         <= dv_d;
      tgt_ram_q    <= tgt_ram_d;
    end
  end

  // Next-state and memory-port steering; idle ports stay at zero
  always_comb begin
    state_d      = state_q;
    size_max_d   = size_max_q;
    mapper_eff_d = mapper_eff_q;
    dv_d         = 1'b0;
    tgt_ram_d    = tgt_ram_q;
    CPU_WAIT     = 1'b0;
    ROM_A        = '0;
    ROM_D        = '0;
    ROM_WE       = 1'b0;
    RAM_A        = '0;
    RAM_D        = '0;
    RAM_WE       = 1'b0;

    case (state_q)
      CART_IDLE: begin
        if (dl_start) begin
          state_d    = CART_LOAD;
          size_max_d = '0;
        end else if (!ROMINIT_ACTIVE) begin
          state_d = CART_RUN;
        end
      end

      CART_LOAD: begin
        CPU_WAIT = 1'b1;
        if (cart_byte) begin
          ROM_WE = 1'b1;
          ROM_A  = ROMINIT_ADDR;
          ROM_D  = ROMINIT_DATA;
          if (ROMINIT_ADDR > size_max_q) size_max_d = ROMINIT_ADDR;
        end
        if (!ROMINIT_ACTIVE) state_d = CART_RESOLVE;
      end

      CART_RESOLVE: begin
        mapper_eff_d = (MAPPER != MAP_AUTO) ? MAPPER : size_to_mapper(size_max_q);
        state_d      = CART_RUN;
      end

      CART_RUN: begin
        if (MAPPER != MAP_AUTO) mapper_eff_d = MAPPER;
        ROM_A  = cmap.rom_a;
        RAM_A  = cmap.ram_a;
        RAM_D  = CPU_D;
        RAM_WE = cpu_wr && cmap.is_ram;
        if (dl_start) begin
          state_d    = CART_LOAD;
          size_max_d = '0;
        end else if (cpu_rd) begin
          dv_d      = 1'b1;
          tgt_ram_d = cmap.is_ram;
        end
      end

      default: state_d = CART_IDLE;
    endcase
  end

  // Read data arrives one cycle after the request from the registered target
  assign CPU_DV     = dv_q;
  assign CPU_Q      = dv_q ? (tgt_ram_q ? RAM_Q : ROM_Q) : 8'h00;
  assign MAPPER_EFF = mapper_eff_q;

endmodule

// File: tb/tb_cart_ctrl.sv
// Bench for cart_ctrl: ROM/RAM array models, a shadow of expected contents,
// a mapping table, directed download/read sequences and random CPU traffic.
module tb_cart_ctrl;
  import scv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_cart;
  logic [16:0] ri_addr;
  logic [7:0]  ri_data;
  logic        ri_valid;
  logic        ri_active;
  mapper_t     mapper;
  logic        ce;
  logic [14:0] cpu_a;
  logic        re;
  logic        we;
  logic [7:0]  cpu_d;
  logic [1:0]  cpu_bank;
  logic [7:0]  cpu_q;
  logic        cpu_dv;
  logic        cpu_wait;
  logic [16:0] rom_a;
  logic [7:0]  rom_d;
  logic        rom_we;
  logic [7:0]  rom_q;
  logic [12:0] ram_a;
  logic [7:0]  ram_d;
  logic        ram_we;
  logic [7:0]  ram_q;
  mapper_t     mapper_eff;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom_mem    [0:131071];
  logic [7:0] ram_mem    [0:8191];
  logic [7:0] shadow_rom [0:131071];
  logic [7:0] shadow_ram [0:8191];

  cart_ctrl dut (
    .CLK(clk), .RESB(rst_n),
    .ROMINIT_SEL_CART(sel_cart), .ROMINIT_ADDR(ri_addr), .ROMINIT_DATA(ri_data),
    .ROMINIT_VALID(ri_valid), .ROMINIT_ACTIVE(ri_active), .MAPPER(mapper),
    .CPU_CE(ce), .CPU_A(cpu_a), .CPU_RE(re), .CPU_WE(we), .CPU_D(cpu_d),
    .CPU_BANK(cpu_bank), .CPU_Q(cpu_q), .CPU_DV(cpu_dv), .CPU_WAIT(cpu_wait),
    .ROM_A(rom_a), .ROM_D(rom_d), .ROM_WE(rom_we), .ROM_Q(rom_q),
    .RAM_A(ram_a), .RAM_D(ram_d), .RAM_WE(ram_we), .RAM_Q(ram_q),
    .MAPPER_EFF(mapper_eff)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bg(input int unsigned a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'(a >> 16) ^ 8'h5A;
  endfunction

  // Image size in bytes addressed by each mapper
  function automatic int unsigned rom_bytes(input mapper_t m);
    case (m)
      MAP_ROM8K:                  return 32'h2000;
      MAP_ROM16K:                 return 32'h4000;
      MAP_ROM32K, MAP_ROM32K_RAM: return 32'h8000;
      MAP_ROM64K:                 return 32'h10000;
      default:                    return 32'h20000;
    endcase
  endfunction

  // Synchronous-read ROM array with background contents
  initial begin
    for (int i = 0; i < 131072; i++) rom_mem[i] = bg(i);
    forever begin
      @(posedge clk);
      if (rom_we) rom_mem[rom_a] <= rom_d;
      rom_q <= rom_mem[rom_a];
    end
  end

  // Synchronous-read RAM array with background contents
  initial begin
    for (int i = 0; i < 8192; i++) ram_mem[i] = bg(i + 32'h3000);
    forever begin
      @(posedge clk);
      if (ram_we) ram_mem[ram_a] <= ram_d;
      ram_q <= ram_mem[ram_a];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, ":cpu_q"},  32'(cpu_q), 0);
    chk({t, ":cpu_dv"}, 32'(cpu_dv), 0);
    chk({t, ":wait"},   32'(cpu_wait), 0);
    chk({t, ":rom_a"},  32'(rom_a), 0);
    chk({t, ":rom_d"},  32'(rom_d), 0);
    chk({t, ":rom_we"}, 32'(rom_we), 0);
    chk({t, ":ram_a"},  32'(ram_a), 0);
    chk({t, ":ram_d"},  32'(ram_d), 0);
    chk({t, ":ram_we"}, 32'(ram_we), 0);
    chk({t, ":eff"},    32'(mapper_eff), 32'(MAP_ROM8K));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string t);
    int n = 0;
    while (dut.state_q != CART_RUN && n < 20) begin
      step();
      n++;
    end
    chk({t, ":reach_run"}, 32'(dut.state_q), 32'(CART_RUN));
  endtask

  task automatic dl_byte(input logic sel, input logic [16:0] a, input logic [7:0] d);
    sel_cart = sel;
    ri_addr  = a;
    ri_data  = d;
    ri_valid = 1'b1;
    @(negedge clk);
    chk("dl_rom_we", 32'(rom_we), 32'(sel));
    if (sel) begin
      chk("dl_rom_a", 32'(rom_a), 32'(a));
      chk("dl_rom_d", 32'(rom_d), 32'(d));
      shadow_rom[a] = d;
    end
    step();
    ri_valid = 1'b0;
  endtask

  task automatic cpu_read(input string t, input logic [1:0] bank, input logic [14:0] a,
                          input logic [16:0] exp_a, input logic exp_ram, input logic [7:0] exp_q);
    ce = 1'b1; re = 1'b1; we = 1'b0; cpu_bank = bank; cpu_a = a;
    @(negedge clk);
    if (exp_ram) chk({t, ":ram_a"}, 32'(ram_a), 32'(exp_a[12:0]));
    else         chk({t, ":rom_a"}, 32'(rom_a), 32'(exp_a));
    step();
    ce = 1'b0; re = 1'b0;
    @(negedge clk);
    chk({t, ":dv"}, 32'(cpu_dv), 1);
    chk({t, ":q"},  32'(cpu_q), 32'(exp_q));
    step();
    @(negedge clk);
    chk({t, ":dv_once"}, 32'(cpu_dv), 0);
    step();
  endtask

  task automatic cpu_write(input string t, input logic [1:0] bank, input logic [14:0] a,
                           input logic [7:0] d, input logic exp_ram);
    ce = 1'b1; re = 1'b0; we = 1'b1; cpu_bank = bank; cpu_a = a; cpu_d = d;
    @(negedge clk);
    chk({t, ":ram_we"}, 32'(ram_we), 32'(exp_ram));
    chk({t, ":rom_we"}, 32'(rom_we), 0);
    if (exp_ram) begin
      chk({t, ":ram_a"}, 32'(ram_a), 32'(a[12:0]));
      chk({t, ":ram_d"}, 32'(ram_d), 32'(d));
      shadow_ram[a[12:0]] = d;
    end
    step();
    ce = 1'b0; we = 1'b0;
  endtask

  typedef struct {
    mapper_t     m;
    logic [1:0]  bank;
    logic [14:0] a;
    logic [16:0] rom_a;
    logic [12:0] ram_a;
    logic        is_ram;
  } vec_t;

  vec_t vecs [12];

  initial begin
    mapper_t     cur_m;
    logic        exp_dv;
    logic [7:0]  exp_q;
    logic        nxt_dv;
    logic [7:0]  nxt_q;
    logic [16:0] m_rom_a;
    logic [12:0] m_ram_a;
    logic        m_ram;
    int unsigned op;

    vecs[0]  = '{MAP_ROM8K,       2'd3, 15'h7FFF, 17'h01FFF, 13'h1FFF, 1'b0};
    vecs[1]  = '{MAP_ROM16K,      2'd0, 15'h4005, 17'h00005, 13'h0005, 1'b0};
    vecs[2]  = '{MAP_ROM32K,      2'd1, 15'h6010, 17'h06010, 13'h0010, 1'b0};
    vecs[3]  = '{MAP_ROM32K_RAM,  2'd1, 15'h6010, 17'h06010, 13'h0010, 1'b1};
    vecs[4]  = '{MAP_ROM32K_RAM,  2'd2, 15'h7FFF, 17'h07FFF, 13'h1FFF, 1'b0};
    vecs[5]  = '{MAP_ROM32K_RAM,  2'd1, 15'h5FFF, 17'h05FFF, 13'h1FFF, 1'b0};
    vecs[6]  = '{MAP_ROM64K,      2'd3, 15'h1234, 17'h09234, 13'h1234, 1'b0};
    vecs[7]  = '{MAP_ROM64K,      2'd2, 15'h1234, 17'h01234, 13'h1234, 1'b0};
    vecs[8]  = '{MAP_ROM128K,     2'd3, 15'h1234, 17'h19234, 13'h1234, 1'b0};
    vecs[9]  = '{MAP_ROM128K,     2'd2, 15'h7FFF, 17'h17FFF, 13'h1FFF, 1'b0};
    vecs[10] = '{MAP_ROM128K_RAM, 2'd0, 15'h6000, 17'h06000, 13'h0000, 1'b1};
    vecs[11] = '{MAP_ROM128K_RAM, 2'd1, 15'h2ABC, 17'h0AABC, 13'h0ABC, 1'b0};

    for (int i = 0; i < 131072; i++) shadow_rom[i] = bg(i);
    for (int i = 0; i < 8192; i++)   shadow_ram[i] = bg(i + 32'h3000);

    // Reset with busy inputs: every output must still read zero
    rst_n = 1'b0;
    sel_cart = 1'b1; ri_addr = 17'h1ABCD; ri_data = 8'hFF; ri_valid = 1'b1; ri_active = 1'b1;
    mapper = MAP_AUTO; ce = 1'b1; cpu_a = 15'h7FFF; re = 1'b1; we = 1'b1;
    cpu_d = 8'hC3; cpu_bank = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    chk("reset:state", 32'(dut.state_q), 32'(CART_IDLE));
    sel_cart = 1'b0; ri_valid = 1'b0; ri_active = 1'b0;
    ce = 1'b0; re = 1'b0; we = 1'b0; cpu_bank = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Boot-ROM download only: nothing written, controller ends up running at ROM8K
    ri_active = 1'b1;
    for (int i = 0; i < 8; i++) dl_byte(1'b0, 17'(i * 3), 8'(i + 1));
    chk("boot:state_idle", 32'(dut.state_q), 32'(CART_IDLE));
    ri_active = 1'b0;
    wait_run("boot");
    chk("boot:eff", 32'(mapper_eff), 32'(MAP_ROM8K));

    // Full 16 KiB AUTO download resolves to ROM16K
    ri_active = 1'b1; sel_cart = 1'b1;
    step();
    chk("dl16:state", 32'(dut.state_q), 32'(CART_LOAD));
    @(negedge clk);
    chk("dl16:wait", 32'(cpu_wait), 1);
    step();
    for (int a = 0; a < 32'h4000; a++) dl_byte(1'b1, 17'(a), 8'($urandom));
    ri_active = 1'b0; sel_cart = 1'b0;
    wait_run("dl16");
    chk("dl16:eff", 32'(mapper_eff), 32'(MAP_ROM16K));
    cpu_read("rd16", 2'b00, 15'h4005, 17'h00005, 1'b0, shadow_rom[5]);

    // Sparse download up to 0x1FFFF with interleaved non-cart bytes
    ri_active = 1'b1; sel_cart = 1'b1;
    step();
    for (int i = 0; i < 2048; i++) begin
      dl_byte(1'b1, 17'(i * 64 + $urandom_range(0, 63)), 8'($urandom));
      if (i % 8 == 0) dl_byte(1'b0, 17'(i * 64 + 1), 8'($urandom));
      sel_cart = 1'b1;
    end
    dl_byte(1'b1, 17'h1FFFF, 8'h3C);
    ri_active = 1'b0; sel_cart = 1'b0;
    wait_run("dl128");
    chk("dl128:eff", 32'(mapper_eff), 32'(MAP_ROM128K));
    cpu_read("rd128", 2'b11, 15'h1234, 17'h19234, 1'b0, shadow_rom[17'h19234]);
    cpu_read("rd128top", 2'b11, 15'h7FFF, 17'h1FFFF, 1'b0, 8'h3C);

    // Mapping table applied through forced mappers and CPU writes
    for (int i = 0; i < 12; i++) begin
      mapper = vecs[i].m;
      step();
      chk("vec:eff", 32'(mapper_eff), 32'(vecs[i].m));
      ce = 1'b1; we = 1'b1; re = 1'b0;
      cpu_bank = vecs[i].bank; cpu_a = vecs[i].a; cpu_d = 8'(8'h30 + i);
      @(negedge clk);
      chk("vec:rom_a",  32'(rom_a), 32'(vecs[i].rom_a));
      chk("vec:ram_a",  32'(ram_a), 32'(vecs[i].ram_a));
      chk("vec:ram_we", 32'(ram_we), 32'(vecs[i].is_ram));
      chk("vec:rom_we", 32'(rom_we), 0);
      if (vecs[i].is_ram) shadow_ram[vecs[i].ram_a] = cpu_d;
      step();
      ce = 1'b0; we = 1'b0;
    end

    // ROM32K_RAM window gated by bank bit 0
    mapper = MAP_ROM32K_RAM;
    step();
    cpu_write("w32r_b1", 2'b01, 15'h6010, 8'hA5, 1'b1);
    cpu_read("r32r_b1", 2'b01, 15'h6010, 17'h00010, 1'b1, 8'hA5);
    cpu_write("w32r_b0", 2'b00, 15'h6010, 8'h5A, 1'b0);
    cpu_read("r32r_b0", 2'b00, 15'h6010, 17'h06010, 1'b0, shadow_rom[17'h06010]);
    cpu_read("r32r_keep", 2'b01, 15'h6010, 17'h00010, 1'b1, 8'hA5);

    // Random traffic against the arithmetic reference
    cur_m = MAP_ROM32K_RAM;
    exp_dv = 1'b0;
    exp_q = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        mapper = mapper_t'(3'($urandom_range(1, 7)));
        ce = 1'b0; re = 1'b0; we = 1'b0;
      end else begin
        op = $urandom_range(0, 3);
        ce = ($urandom_range(0, 7) != 0);
        re = op[0];
        we = op[1];
        cpu_bank = 2'($urandom);
        cpu_a = ($urandom_range(0, 1) != 0) ? 15'(15'h6000 + $urandom_range(0, 32'h1FFF))
                                             : 15'($urandom);
        cpu_d = 8'($urandom);
      end
      m_rom_a = 17'((32'(cpu_bank) * 32'h8000 + 32'(cpu_a)) % rom_bytes(cur_m));
      m_ram_a = 13'(32'(cpu_a) % 32'h2000);
      m_ram = (cpu_a >= 15'h6000) &&
              ((cur_m == MAP_ROM128K_RAM) || (cur_m == MAP_ROM32K_RAM && cpu_bank[0]));
      @(negedge clk);
      chk("rnd:eff", 32'(mapper_eff), 32'(cur_m));
      chk("rnd:dv", 32'(cpu_dv), 32'(exp_dv));
      if (exp_dv) chk("rnd:q", 32'(cpu_q), 32'(exp_q));
      chk("rnd:rom_we", 32'(rom_we), 0);
      chk("rnd:ram_we", 32'(ram_we), 32'(ce && we && m_ram));
      if (ce && (re || we)) begin
        chk("rnd:rom_a", 32'(rom_a), 32'(m_rom_a));
        if (m_ram) chk("rnd:ram_a", 32'(ram_a), 32'(m_ram_a));
      end
      nxt_dv = ce && re && !we;
      nxt_q  = m_ram ? shadow_ram[m_ram_a] : shadow_rom[m_rom_a];
      if (ce && we && m_ram) shadow_ram[m_ram_a] = cpu_d;
      step();
      exp_dv = nxt_dv;
      exp_q  = nxt_q;
      cur_m  = mapper;
    end
    ce = 1'b0; re = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("rnd:dv_drain", 32'(cpu_dv), 32'(exp_dv));
    if (exp_dv) chk("rnd:q_drain", 32'(cpu_q), 32'(exp_q));
    step();

    // Download start alongside a read cancels the data valid; empty image -> ROM8K
    mapper = MAP_ROM128K;
    step();
    chk("cancel:eff_pre", 32'(mapper_eff), 32'(MAP_ROM128K));
    mapper = MAP_AUTO;
    ce = 1'b1; re = 1'b1; cpu_a = 15'h0100; cpu_bank = 2'b00;
    ri_active = 1'b1; sel_cart = 1'b1;
    step();
    @(negedge clk);
    chk("cancel:dv", 32'(cpu_dv), 0);
    chk("cancel:wait", 32'(cpu_wait), 1);
    chk("cancel:state", 32'(dut.state_q), 32'(CART_LOAD));
    step();
    ce = 1'b0; re = 1'b0;
    @(negedge clk);
    chk("load:dv", 32'(cpu_dv), 0);
    step();
    ri_active = 1'b0; sel_cart = 1'b0;
    wait_run("empty");
    chk("empty:eff", 32'(mapper_eff), 32'(MAP_ROM8K));

    // Asynchronous reset in the middle of a download
    mapper = MAP_ROM64K;
    step();
    chk("arst:eff_pre", 32'(mapper_eff), 32'(MAP_ROM64K));
    mapper = MAP_AUTO;
    ri_active = 1'b1; sel_cart = 1'b1;
    step();
    dl_byte(1'b1, 17'h00123, 8'h77);
    ri_addr = 17'h00124; ri_data = 8'h88; ri_valid = 1'b1;
    @(negedge clk);
    chk("arst:rom_we_pre", 32'(rom_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    chk("arst:state", 32'(dut.state_q), 32'(CART_IDLE));
    ri_valid = 1'b0; ri_active = 1'b0; sel_cart = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
